// File: rtl/controller_ram_pkg.sv
// Shared constants for the on-chip RAM arbiter: bus geometry, populated size
// and the value returned for out-of-range reads.
package controller_ram_pkg;

    localparam int ADDR_W    = 14;
    localparam int DATA_W    = 32;
    localparam int BE_W      = DATA_W / 8;
    localparam int NUM_WORDS = 12288;

    localparam logic [DATA_W-1:0] OOB_RDATA = '0;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
        return addr <= LAST_ADDR;
    endfunction

endpackage

// File: rtl/controller_onchip_ram_arbiter_if.sv
// Avalon-MM master-side bundle for one requester of the on-chip RAM arbiter.
interface controller_onchip_ram_arbiter_if;
    import controller_ram_pkg::*;

    logic [ADDR_W-1:0] address;
    logic [BE_W-1:0]   byteenable;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic              waitrequest;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;

    modport master (
        output address, byteenable, read, write, writedata,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, byteenable, read, write, writedata,
        output waitrequest, readdata, readdatavalid
    );

endinterface

// File: rtl/controller_rr_arb2.sv
// Two-requester round-robin arbiter; on a tie the requester not granted last
// wins. Grant is combinational and one-hot (or zero when idle or disabled).
module controller_rr_arb2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    // rr_last = 1 means requester 1 was granted most recently
    logic rr_last;

    always_comb begin
        grant = 2'b00;
        if (en) begin
            unique case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = rr_last ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_last <= 1'b1;
        end else if (grant[0]) begin
            rr_last <= 1'b0;
        end else if (grant[1]) begin
            rr_last <= 1'b1;
        end
    end

endmodule

// File: rtl/controller_onchip_ram_arbiter.sv
// Shares the single-port on-chip RAM between two Avalon-MM masters with
// round-robin arbitration, 1-cycle read latency and debug status.
module controller_onchip_ram_arbiter
    import controller_ram_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,

    controller_onchip_ram_arbiter_if.slave m0,
    controller_onchip_ram_arbiter_if.slave m1,

    output logic [ADDR_W-1:0]     ram_address,
    output logic [BE_W-1:0]       ram_byteenable,
    output logic                  ram_chipselect,
    output logic                  ram_write,
    output logic [DATA_W-1:0]     ram_writedata,
    output logic                  ram_clken,
    input  logic [DATA_W-1:0]     ram_readdata,

    output logic                  oob_err,
    input  logic                  oob_clr,
    output logic [CNT_W-1:0]      conflict_cnt
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic       ready;
    logic       req0, req1;
    logic [1:0] gnt;
    logic       gnt_any;
    logic       sel1;
    logic       cmd_rd, cmd_wr;
    logic       addr_ok;
    logic       rd_issue;
    logic       oob_set;

    logic              vld_p1;
    logic              src_p1;
    logic              oob_p1;
    logic [DATA_W-1:0] rdata_p1;

    // ---- stage 0: arbitration and RAM command ----
    assign req0 = m0.read | m0.write;
    assign req1 = m1.read | m1.write;

    // Holds off grants for the first cycle after reset release
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready <= 1'b0;
        end else begin
            ready <= 1'b1;
        end
    end

    controller_rr_arb2 u_rr_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (ready),
        .req     ({req1, req0}),
        .grant   (gnt)
    );

    assign gnt_any        = |gnt;
    assign sel1           = gnt[1];
    assign m0.waitrequest = ~gnt[0];
    assign m1.waitrequest = ~gnt[1];

    assign ram_address    = sel1 ? m1.address    : m0.address;
    assign ram_byteenable = sel1 ? m1.byteenable : m0.byteenable;
    assign ram_writedata  = sel1 ? m1.writedata  : m0.writedata;
    assign cmd_rd         = sel1 ? m1.read       : m0.read;
    assign cmd_wr         = sel1 ? m1.write      : m0.write;

    assign addr_ok        = addr_in_range(ram_address);
    assign ram_chipselect = gnt_any & addr_ok;
    assign ram_write      = ram_chipselect & cmd_wr;
    assign ram_clken      = 1'b1;

    // Read+write together is handled as a write but flagged like a bad access
    assign rd_issue = gnt_any & cmd_rd & ~cmd_wr;
    assign oob_set  = gnt_any & (~addr_ok | (cmd_rd & cmd_wr));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1 <= 1'b0;
            src_p1 <= 1'b0;
            oob_p1 <= 1'b0;
        end else begin
            vld_p1 <= rd_issue;
            src_p1 <= sel1;
            oob_p1 <= ~addr_ok;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            oob_err <= 1'b0;
        end else if (oob_set) begin
            oob_err <= 1'b1;
        end else if (oob_clr) begin
            oob_err <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            conflict_cnt <= '0;
        end else if (req0 & req1) begin
            conflict_cnt <= sat_inc(conflict_cnt);
        end
    end

    // ---- stage 1: read response routed to the issuing master ----
    assign rdata_p1 = oob_p1 ? OOB_RDATA : ram_readdata;

    assign m0.readdatavalid = vld_p1 & ~src_p1;
    assign m1.readdatavalid = vld_p1 &  src_p1;
    assign m0.readdata      = m0.readdatavalid ? rdata_p1 : '0;
    assign m1.readdata      = m1.readdatavalid ? rdata_p1 : '0;

endmodule

// File: tb/tb_controller_onchip_ram_arbiter.sv
// Directed bench for controller_onchip_ram_arbiter with a behavioural RAM.
module tb_controller_onchip_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [13:0] ram_address;
    logic [3:0]  ram_byteenable;
    logic        ram_chipselect;
    logic        ram_write;
    logic [31:0] ram_writedata;
    logic        ram_clken;
    logic [31:0] ram_readdata;
    logic        oob_err;
    logic        oob_clr;
    logic [15:0] conflict_cnt;

    int n_cmp = 0;
    int n_err = 0;

    controller_onchip_ram_arbiter_if m0_if ();
    controller_onchip_ram_arbiter_if m1_if ();

    controller_onchip_ram_arbiter #(.CNT_W(16)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .m0             (m0_if),
        .m1             (m1_if),
        .ram_address    (ram_address),
        .ram_byteenable (ram_byteenable),
        .ram_chipselect (ram_chipselect),
        .ram_write      (ram_write),
        .ram_writedata  (ram_writedata),
        .ram_clken      (ram_clken),
        .ram_readdata   (ram_readdata),
        .oob_err        (oob_err),
        .oob_clr        (oob_clr),
        .conflict_cnt   (conflict_cnt)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:12287];

    always @(posedge clk) begin
        if (ram_clken && ram_chipselect) begin
            if (ram_write) begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_byteenable[b]) mem[ram_address][b*8 +: 8] <= ram_writedata[b*8 +: 8];
                end
            end else begin
                ram_readdata <= mem[ram_address];
            end
        end
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drv0(input logic rd, input logic wr, input logic [13:0] a,
                        input logic [31:0] d, input logic [3:0] be);
        m0_if.read = rd; m0_if.write = wr; m0_if.address = a;
        m0_if.writedata = d; m0_if.byteenable = be;
    endtask

    task automatic drv1(input logic rd, input logic wr, input logic [13:0] a,
                        input logic [31:0] d, input logic [3:0] be);
        m1_if.read = rd; m1_if.write = wr; m1_if.address = a;
        m1_if.writedata = d; m1_if.byteenable = be;
    endtask

    task automatic idle();
        drv0(1'b0, 1'b0, 14'd0, 32'd0, 4'h0);
        drv1(1'b0, 1'b0, 14'd0, 32'd0, 4'h0);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int r0, r1;
        logic e0;
        idle();
        oob_clr = 1'b0;
        reset_n = 1'b0;
        drv0(1'b1, 1'b0, 14'd5, 32'd0, 4'hF);
        repeat (2) @(posedge clk);
        #2;
        chk1("rst_m0_wait", m0_if.waitrequest, 1'b1);
        chk1("rst_m1_wait", m1_if.waitrequest, 1'b1);
        chk1("rst_cs", ram_chipselect, 1'b0);
        chk1("rst_wr", ram_write, 1'b0);
        chk1("rst_m0_rdv", m0_if.readdatavalid, 1'b0);
        chk32("rst_m0_rdata", m0_if.readdata, 32'h0);
        chk1("rst_oob", oob_err, 1'b0);
        chk32("rst_cnt", 32'(conflict_cnt), 32'h0);

        // Release: first cycle still stalls
        cyc();
        reset_n = 1'b1;
        drv0(1'b0, 1'b1, 14'd5, 32'h12345678, 4'hF);
        #1;
        chk1("rel_m0_wait", m0_if.waitrequest, 1'b1);
        chk1("rel_cs", ram_chipselect, 1'b0);
        cyc(); #1;
        chk1("wr5_wait", m0_if.waitrequest, 1'b0);
        chk1("wr5_cs", ram_chipselect, 1'b1);
        chk1("wr5_wr", ram_write, 1'b1);
        chk32("wr5_addr", 32'(ram_address), 32'd5);
        chk32("wr5_data", ram_writedata, 32'h12345678);
        cyc();
        drv0(1'b1, 1'b0, 14'd5, 32'd0, 4'hF);
        #1;
        chk1("rd5_wait", m0_if.waitrequest, 1'b0);
        chk1("rd5_wr", ram_write, 1'b0);
        chk1("rd5_rdv_early", m0_if.readdatavalid, 1'b0);
        cyc();
        idle();
        #1;
        chk1("rd5_rdv", m0_if.readdatavalid, 1'b1);
        chk32("rd5_data", m0_if.readdata, 32'h12345678);
        chk1("rd5_m1_rdv", m1_if.readdatavalid, 1'b0);
        chk32("rd5_m1_data", m1_if.readdata, 32'h0);
        chk1("idle_wait", m0_if.waitrequest, 1'b1);

        // Seed addresses 1 and 2
        cyc();
        drv0(1'b0, 1'b1, 14'd1, 32'h11111111, 4'hF);
        cyc();
        drv0(1'b0, 1'b0, 14'd0, 32'd0, 4'h0);
        drv1(1'b0, 1'b1, 14'd2, 32'h22222222, 4'hF);
        #1;
        chk1("wr2_m1_wait", m1_if.waitrequest, 1'b0);

        // Six cycles of contention: m0, m1, m0, ...
        r0 = 0; r1 = 0;
        for (int k = 0; k < 6; k++) begin
            cyc();
            drv0(1'b1, 1'b0, 14'd1, 32'd0, 4'hF);
            drv1(1'b1, 1'b0, 14'd2, 32'd0, 4'hF);
            #1;
            e0 = (k % 2) == 0;
            chk1("con_m0_wait", m0_if.waitrequest, !e0);
            chk1("con_m1_wait", m1_if.waitrequest, e0);
            chk32("con_addr", 32'(ram_address), e0 ? 32'd1 : 32'd2);
            if (k > 0) begin
                chk1("con_m0_rdv", m0_if.readdatavalid, !e0);
                chk1("con_m1_rdv", m1_if.readdatavalid, e0);
                chk32("con_m0_data", m0_if.readdata, !e0 ? 32'h11111111 : 32'h0);
                chk32("con_m1_data", m1_if.readdata, e0 ? 32'h22222222 : 32'h0);
            end
            r0 += int'(m0_if.readdatavalid);
            r1 += int'(m1_if.readdatavalid);
        end
        cyc();
        idle();
        #1;
        chk1("con_last_m1_rdv", m1_if.readdatavalid, 1'b1);
        chk32("con_last_m1_data", m1_if.readdata, 32'h22222222);
        r0 += int'(m0_if.readdatavalid);
        r1 += int'(m1_if.readdatavalid);
        chk32("con_m0_count", 32'(r0), 32'd3);
        chk32("con_m1_count", 32'(r1), 32'd3);
        chk32("con_cnt", 32'(conflict_cnt), 32'd6);

        // Out-of-range write and read
        cyc();
        drv1(1'b0, 1'b1, 14'd12288, 32'hAAAA5555, 4'hF);
        #1;
        chk1("oobw_wait", m1_if.waitrequest, 1'b0);
        chk1("oobw_cs", ram_chipselect, 1'b0);
        chk1("oobw_wr", ram_write, 1'b0);
        chk1("oobw_err_pre", oob_err, 1'b0);
        cyc();
        idle();
        #1;
        chk1("oobw_err", oob_err, 1'b1);
        cyc();
        drv1(1'b1, 1'b0, 14'd12288, 32'd0, 4'hF);
        oob_clr = 1'b1;
        #1;
        chk1("oobr_cs", ram_chipselect, 1'b0);
        chk1("oobr_wait", m1_if.waitrequest, 1'b0);
        cyc();
        idle();
        #1;
        chk1("oobr_rdv", m1_if.readdatavalid, 1'b1);
        chk32("oobr_data", m1_if.readdata, 32'h0);
        chk1("oobr_m0_rdv", m0_if.readdatavalid, 1'b0);
        chk1("oob_set_wins", oob_err, 1'b1);
        cyc();
        oob_clr = 1'b0;
        #1;
        chk1("oob_cleared", oob_err, 1'b0);

        // Illegal read+write: treated as write, flagged
        cyc();
        drv0(1'b1, 1'b1, 14'd9, 32'h00000009, 4'hF);
        #1;
        chk1("ill_cs", ram_chipselect, 1'b1);
        chk1("ill_wr", ram_write, 1'b1);
        cyc();
        idle();
        #1;
        chk1("ill_rdv", m0_if.readdatavalid, 1'b0);
        chk1("ill_err", oob_err, 1'b1);
        oob_clr = 1'b1;
        cyc();
        oob_clr = 1'b0;

        // Byteenable merge
        drv0(1'b0, 1'b1, 14'd7, 32'hFFFFFFFF, 4'hF);
        cyc();
        drv0(1'b0, 1'b1, 14'd7, 32'h00000000, 4'b0101);
        cyc();
        drv0(1'b1, 1'b0, 14'd7, 32'd0, 4'hF);
        cyc();
        idle();
        #1;
        chk1("be_rdv", m0_if.readdatavalid, 1'b1);
        chk32("be_data", m0_if.readdata, 32'hFF00FF00);

        // Reset with a read response in flight
        cyc();
        drv0(1'b1, 1'b0, 14'd7, 32'd0, 4'hF);
        #1;
        chk1("inflt_wait", m0_if.waitrequest, 1'b0);
        #1;
        reset_n = 1'b0;
        #1;
        chk1("inflt_rst_wait", m0_if.waitrequest, 1'b1);
        chk1("inflt_rst_cs", ram_chipselect, 1'b0);
        chk32("inflt_rst_cnt", 32'(conflict_cnt), 32'h0);
        cyc();
        idle();
        #1;
        chk1("inflt_rdv", m0_if.readdatavalid, 1'b0);
        chk32("inflt_rdata", m0_if.readdata, 32'h0);
        cyc();
        reset_n = 1'b1;
        #1;
        chk1("inflt_rel_rdv", m0_if.readdatavalid, 1'b0);
        cyc();
        drv0(1'b1, 1'b0, 14'd7, 32'd0, 4'hF);
        drv1(1'b1, 1'b0, 14'd1, 32'd0, 4'hF);
        #1;
        chk1("post_rst_m0_wins", m0_if.waitrequest, 1'b0);
        chk1("post_rst_m1_waits", m1_if.waitrequest, 1'b1);
        cyc(); #1;
        chk1("post_rst_m0_rdv", m0_if.readdatavalid, 1'b1);
        chk32("post_rst_m0_data", m0_if.readdata, 32'hFF00FF00);
        chk1("post_rst_m1_wins", m1_if.waitrequest, 1'b0);
        cyc(); #1;
        chk1("post_rst_m1_rdv", m1_if.readdatavalid, 1'b1);
        chk32("post_rst_m1_data", m1_if.readdata, 32'h11111111);
        chk32("post_rst_cnt", 32'(conflict_cnt), 32'd2);

        // Saturation of the contention counter
        repeat (65532) @(posedge clk);
        #1;
        chk32("sat_below", 32'(conflict_cnt), 32'h0000FFFE);
        cyc();
        chk32("sat_hit", 32'(conflict_cnt), 32'h0000FFFF);
        repeat (4) cyc();
        chk32("sat_hold", 32'(conflict_cnt), 32'h0000FFFF);

        idle();
        cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
